// File: rtl/board_scan_reader.sv
// -----------------------------------------------------------------------------
// board_scan_reader
//
// Read-side sequencer for the dual-port board memory. A start pulse latches
// base_addr and the block reads CELLS consecutive words through RAM port B
// (addresses wrap modulo 2^ADDR_W). It presents each word on a valid/ready
// stream for the display/compare logic. Port A belongs to the board-update
// FSM. This block never writes, so wen_b is tied low.
//
// Parameters:
//   CELLS   number of consecutive words read per scan (1..2^ADDR_W)
//   ADDR_W  RAM address width
//   DATA_W  RAM word width
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous, active-high
//   start       one-cycle scan request, sampled only in IDLE
//   base_addr   first cell address, latched on accepted start
//   busy        high from the cycle after accepted start through DONE
//   done        one-cycle pulse after the last word is accepted
//   addr_b      registered RAM port-B address
//   wen_b       RAM port-B write enable, constant 0
//   dout_b      RAM port-B read data, one cycle after addr_b is sampled
//   cell_data   registered word being presented
//   cell_index  offset of cell_data within the scan
//   cell_valid  cell_data/cell_index valid
//   cell_ready  consumer accepts when cell_valid && cell_ready
//   checksum    running modulo-2^DATA_W sum of accepted words
//
// Optional feature macro: BOARD_SCAN_CHECKSUM_EN
//   defined     -> checksum accumulates the accepted words of the current scan
//   undefined   -> checksum is constant 0 and no accumulator is built
// -----------------------------------------------------------------------------
module board_scan_reader #(
    parameter int CELLS  = 11,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr_b,
    output logic              wen_b,
    input  logic [DATA_W-1:0] dout_b,
    output logic [DATA_W-1:0] cell_data,
    output logic [ADDR_W-1:0] cell_index,
    output logic              cell_valid,
    input  logic              cell_ready,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] ONE_ADDR = ADDR_W'(1);

    state_t            state_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] idx_r;

    // The RAM is read-only from this side.
    assign wen_b = 1'b0;

    // Scan sequencer: state, address generation and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            base_r     <= {ADDR_W{1'b0}};
            idx_r      <= {ADDR_W{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            addr_b     <= {ADDR_W{1'b0}};
            cell_data  <= {DATA_W{1'b0}};
            cell_index <= {ADDR_W{1'b0}};
            cell_valid <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the OUT->DONE transition raises it.
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        base_r  <= base_addr;
                        idx_r   <= {ADDR_W{1'b0}};
                        addr_b  <= base_addr;
                        busy    <= 1'b1;
                        state_r <= S_ADDR;
                    end
                end
                // The RAM samples addr_b at the end of this cycle.
                S_ADDR: begin
                    state_r <= S_WAIT;
                end
                // dout_b now holds the addressed word; capture it for the stream.
                S_WAIT: begin
                    cell_data  <= dout_b;
                    cell_index <= idx_r;
                    cell_valid <= 1'b1;
                    state_r    <= S_OUT;
                end
                // Hold the word until the consumer takes it.
                S_OUT: begin
                    if (cell_ready) begin
                        cell_valid <= 1'b0;
                        if (idx_r == LAST_IDX) begin
                            done    <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            idx_r   <= idx_r + ONE_ADDR;
                            // Wraps naturally at 2^ADDR_W.
                            addr_b  <= base_r + idx_r + ONE_ADDR;
                            state_r <= S_ADDR;
                        end
                    end
                end
                // start is deliberately not looked at here.
                S_DONE: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy       <= 1'b0;
                    cell_valid <= 1'b0;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BOARD_SCAN_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_r;

    // Accumulator: clears on accepted start, adds each accepted word, then
    // holds its final value until the next accepted start or reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_r <= {DATA_W{1'b0}};
        end else if ((state_r == S_IDLE) && start) begin
            checksum_r <= {DATA_W{1'b0}};
        end else if ((state_r == S_OUT) && cell_ready) begin
            checksum_r <= checksum_r + cell_data;
        end
    end

    assign checksum = checksum_r;
`else
    assign checksum = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_board_scan_reader.sv
// -----------------------------------------------------------------------------
// tb_board_scan_reader
//
// Self-checking bench for board_scan_reader. Two instances are used: one with
// the default CELLS=11 and one with CELLS=4 for the address-wrap case. Each has
// its own behavioural RAM with a registered read port. Expected words, indices,
// addresses, timing and checksums come from a scan model: word k of a scan is
// mem[(base+k) mod 1024]. The first word is valid 3 cycles after start. done
// lands at 3*CELLS+1 plus one cycle per stalled OUT cycle.
// -----------------------------------------------------------------------------
module tb_board_scan_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start_a = 1'b0, start_b = 1'b0;
    logic [9:0]  base_a = 10'd0, base_b = 10'd0;
    logic        ready_a = 1'b0, ready_b = 1'b0;
    logic        busy_a, busy_b, done_a, done_b, wen_a, wen_b, valid_a, valid_b;
    logic [9:0]  addr_a, addr_b, index_a, index_b;
    logic [15:0] data_a, data_b, csum_a, csum_b;
    logic [15:0] rd_a = 16'd0, rd_b = 16'd0;

    logic [15:0] mem_a [1024];
    logic [15:0] mem_b [1024];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          sel      = 0;
    int          acc_cyc  [16];
    logic [15:0] acc_data [16];

    always #5 clk = ~clk;

    board_scan_reader #(.CELLS(11), .ADDR_W(10), .DATA_W(16)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .base_addr(base_a),
        .busy(busy_a), .done(done_a), .addr_b(addr_a), .wen_b(wen_a),
        .dout_b(rd_a), .cell_data(data_a), .cell_index(index_a),
        .cell_valid(valid_a), .cell_ready(ready_a), .checksum(csum_a)
    );

    board_scan_reader #(.CELLS(4), .ADDR_W(10), .DATA_W(16)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .base_addr(base_b),
        .busy(busy_b), .done(done_b), .addr_b(addr_b), .wen_b(wen_b),
        .dout_b(rd_b), .cell_data(data_b), .cell_index(index_b),
        .cell_valid(valid_b), .cell_ready(ready_b), .checksum(csum_b)
    );

    // Synchronous-read RAM models, one per instance
    always @(posedge clk) begin
        rd_a <= mem_a[addr_a];
        rd_b <= mem_b[addr_b];
    end

    // View of whichever instance is under test
    logic        m_busy, m_done, m_wen, m_valid;
    logic [9:0]  m_addr, m_index;
    logic [15:0] m_data, m_csum;
    assign m_busy  = (sel == 1) ? busy_b  : busy_a;
    assign m_done  = (sel == 1) ? done_b  : done_a;
    assign m_wen   = (sel == 1) ? wen_b   : wen_a;
    assign m_valid = (sel == 1) ? valid_b : valid_a;
    assign m_addr  = (sel == 1) ? addr_b  : addr_a;
    assign m_index = (sel == 1) ? index_b : index_a;
    assign m_data  = (sel == 1) ? data_b  : data_a;
    assign m_csum  = (sel == 1) ? csum_b  : csum_a;

    typedef struct {
        int sel;
        int base;
        int stall_idx;
        int stall_len;
        bit extra;
        int exp_done;
    } scn_t;

    typedef struct {
        int          k;
        logic [15:0] data;
        int          cyc;
    } word_t;

    scn_t  scn [5];
    word_t wt  [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic rdy, input logic [9:0] base);
        if (sel == 1) begin
            start_b = st; ready_b = rdy; base_b = base;
            start_a = 1'b0; ready_a = 1'b0;
        end else begin
            start_a = st; ready_a = rdy; base_a = base;
            start_b = 1'b0; ready_b = 1'b0;
        end
    endtask

    function automatic logic [15:0] mem_rd(input int s, input int a);
        if (s == 1) return mem_b[a % 1024];
        return mem_a[a % 1024];
    endfunction

    // Runs one scan on the selected instance and checks it cycle by cycle.
    task automatic run_scan(input int sel_i, input int base, input int stall_idx,
                            input int stall_len, input bit rand_rdy, input bit extra,
                            output int done_cyc);
        int          cells, k, cyc, stalls, stall_cnt, first_valid, ea;
        logic [15:0] sum;
        logic        rdy;
        sel = sel_i;
        cells = (sel_i == 1) ? 4 : 11;
        k = 0; stalls = 0; stall_cnt = 0; first_valid = -1; done_cyc = -1;
        sum = 16'd0;
        @(negedge clk);
        drive(1'b1, 1'($urandom_range(0, 1)), 10'(base));
        @(posedge clk); #1;
        cyc = 1;
        while (cyc < 400 && done_cyc < 0) begin
            chk("busy", 32'(m_busy), 32'd1);
            chk("wen_b", 32'(m_wen), 32'd0);
            ea = (base + ((k < cells) ? k : cells - 1)) % 1024;
            chk("addr_b", 32'(m_addr), 32'(ea));
            if (m_done) begin
                done_cyc = cyc;
                chk("done_after_last", 32'(k), 32'(cells));
                chk("done_cycle", 32'(cyc), 32'(3 * cells + 1 + stalls));
                chk("valid_in_done", 32'(m_valid), 32'd0);
`ifdef BOARD_SCAN_CHECKSUM_EN
                chk("checksum_done", 32'(m_csum), 32'(sum));
`else
                chk("checksum_zero", 32'(m_csum), 32'd0);
`endif
                drive(extra, 1'($urandom_range(0, 1)), 10'($urandom));
            end else begin
                if (m_valid) begin
                    if (first_valid < 0) begin
                        first_valid = cyc;
                        chk("first_valid_cycle", 32'(cyc), 32'd3);
                    end
                    chk("cell_data", 32'(m_data), 32'(mem_rd(sel_i, base + k)));
                    chk("cell_index", 32'(m_index), 32'(k));
                    if (k == stall_idx && stall_cnt < stall_len) begin
                        rdy = 1'b0; stall_cnt++; stalls++;
                    end else if (rand_rdy) begin
                        rdy = 1'($urandom_range(0, 1));
                        if (!rdy) stalls++;
                    end else begin
                        rdy = 1'b1;
                    end
                    if (rdy) begin
                        acc_cyc[k] = cyc;
                        acc_data[k] = m_data;
                        sum = sum + m_data;
                        k++;
                    end
                end else begin
                    rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                drive(extra && (cyc == 5 || cyc == 20), rdy, 10'($urandom));
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (done_cyc < 0) chk("done_timeout", 32'd0, 32'd1);
        drive(1'b0, 1'b0, 10'd0);
        chk("busy_after_done", 32'(m_busy), 32'd0);
        chk("done_single_pulse", 32'(m_done), 32'd0);
        chk("valid_after_done", 32'(m_valid), 32'd0);
        @(posedge clk); #1;
        chk("idle_busy", 32'(m_busy), 32'd0);
`ifdef BOARD_SCAN_CHECKSUM_EN
        chk("checksum_hold", 32'(m_csum), 32'(sum));
`else
        chk("checksum_zero_idle", 32'(m_csum), 32'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int cyc;

        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 16'($urandom);
            mem_b[i] = 16'($urandom);
        end
        for (int i = 0; i < 11; i++) mem_a[i] = 16'h0100 + 16'(i);
        mem_b[1022] = 16'hAAAA; mem_b[1023] = 16'hBBBB;
        mem_b[0]    = 16'hCCCC; mem_b[1]    = 16'hDDDD;

        scn[0] = '{0, 0,    -1, 0, 1'b0, 34};
        scn[1] = '{0, 0,     3, 5, 1'b0, 39};
        scn[2] = '{1, 1022, -1, 0, 1'b0, 13};
        scn[3] = '{0, 0,    -1, 0, 1'b1, 34};
        scn[4] = '{1, 3,     2, 3, 1'b0, 16};
        for (int i = 0; i < 11; i++) wt[i] = '{i, 16'h0100 + 16'(i), 3 + 3 * i};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            chk("rst_busy", 32'(m_busy), 32'd0);
            chk("rst_done", 32'(m_done), 32'd0);
            chk("rst_addr", 32'(m_addr), 32'd0);
            chk("rst_wen", 32'(m_wen), 32'd0);
            chk("rst_data", 32'(m_data), 32'd0);
            chk("rst_index", 32'(m_index), 32'd0);
            chk("rst_valid", 32'(m_valid), 32'd0);
            chk("rst_csum", 32'(m_csum), 32'd0);
        end
        reset = 1'b0;

        // Directed scenarios
        for (int i = 0; i < 5; i++) begin
            run_scan(scn[i].sel, scn[i].base, scn[i].stall_idx, scn[i].stall_len,
                     1'b0, scn[i].extra, dc);
            chk("scn_done_cycle", 32'(dc), 32'(scn[i].exp_done));
            if (i == 0) begin
                for (int j = 0; j < 11; j++) begin
                    chk("word_cycle", 32'(acc_cyc[wt[j].k]), 32'(wt[j].cyc));
                    chk("word_data", 32'(acc_data[wt[j].k]), 32'(wt[j].data));
                end
`ifdef BOARD_SCAN_CHECKSUM_EN
                chk("checksum_const", 32'(m_csum), 32'h0B37);
`else
                chk("checksum_const", 32'(m_csum), 32'd0);
`endif
            end
        end

        // Reset during WAIT of index 6 (cycle 20)
        sel = 0;
        @(negedge clk);
        drive(1'b1, 1'b1, 10'd0);
        @(posedge clk); #1;
        cyc = 1;
        drive(1'b0, 1'b1, 10'd0);
        while (cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("pre_reset_valid", 32'(m_valid), 32'd0);
        chk("pre_reset_addr", 32'(m_addr), 32'd6);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_busy", 32'(m_busy), 32'd0);
        chk("mid_rst_done", 32'(m_done), 32'd0);
        chk("mid_rst_addr", 32'(m_addr), 32'd0);
        chk("mid_rst_data", 32'(m_data), 32'd0);
        chk("mid_rst_index", 32'(m_index), 32'd0);
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_csum", 32'(m_csum), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("post_rst_done", 32'(m_done), 32'd0);
            chk("post_rst_addr", 32'(m_addr), 32'd0);
            chk("post_rst_busy", 32'(m_busy), 32'd0);
        end
        run_scan(0, 0, -1, 0, 1'b0, 1'b0, dc);
        chk("rescan_done_cycle", 32'(dc), 32'd34);

        // Randomized scans with random backpressure against the scan model
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 1024; i++) begin
                mem_a[i] = 16'($urandom);
                mem_b[i] = 16'($urandom);
            end
            run_scan(int'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
                     -1, 0, 1'b1, 1'(r & 1), dc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/board_scan_reader.md
# board_scan_reader

Read-side sequencer for the dual-port board memory. On a start pulse it reads a fixed run of consecutive board cells through RAM port B and presents each 16-bit word on a valid/ready stream for the display/compare logic. Port A stays with the board-update FSM, which writes cells 0–10. This block never writes.

## Interface
- CELLS, 11, number of consecutive words read per scan (1..2^ADDR_W)
- ADDR_W, 10, RAM address width
- DATA_W, 16, RAM word width
- clk  in  1  clock; all logic rising-edge
- reset  in  1  synchronous, active-high; clock clk
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE
- base_addr  in  ADDR_W  first cell address; latched on accepted start
- busy  out  1  high from the cycle after accepted start until DONE completes
- done  out  1  one-cycle pulse after the last word is accepted
- addr_b  out  ADDR_W  registered RAM port-B address
- wen_b  out  1  RAM port-B write enable; constant 0
- dout_b  in  DATA_W  RAM port-B read data, valid one cycle after addr_b is sampled
- cell_data  out  DATA_W  registered word being presented
- cell_index  out  ADDR_W  offset (0..CELLS-1) of cell_data within the scan
- cell_valid  out  1  cell_data/cell_index valid
- cell_ready  in  1  consumer accepts when cell_valid && cell_ready
- checksum  out  DATA_W  running word sum (see Configuration)

## Operation
- States: IDLE, ADDR, WAIT, OUT, DONE.
- IDLE: busy=0, cell_valid=0. If start=1, latch base_addr, set idx=0 and addr_b=base_addr, and go to ADDR.
- ADDR: addr_b is stable and the RAM samples it at the end of this cycle. Go to WAIT.
- WAIT: dout_b holds mem[addr_b]. At the cycle end, set cell_data←dout_b, cell_index←idx, cell_valid←1, and go to OUT.
- OUT: hold cell_data, cell_index and cell_valid=1 until cell_ready=1. On accept:
  - if idx==CELLS-1, set cell_valid←0 and go to DONE;
  - otherwise set idx←idx+1, addr_b←base+idx+1, cell_valid←0, and go to ADDR.
- DONE: done=1 and busy=1 for this one cycle, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W. Example: base=1022 with CELLS=4 reads 1022, 1023, 0, 1.
- start is ignored in every state except IDLE. A start in the same cycle as DONE is ignored.
- cell_ready is ignored while cell_valid=0.
- wen_b is tied 0. The block never drives RAM write data.

## Timing
- Reset values: busy=0, done=0, addr_b=0, wen_b=0, cell_data=0, cell_index=0, cell_valid=0, checksum=0. State returns to IDLE.
- Reset mid-scan aborts immediately. No done pulse, and no further port-B address changes until the next start.
- Cycle 0 = the edge sampling start=1. State is ADDR in cycle 1, WAIT in cycle 2, and cell_valid=1 from cycle 3.
- Start-to-first-valid latency: 3 cycles.
- With cell_ready held high, one word is accepted every 3 cycles. A scan of CELLS words puts done in cycle 3·CELLS+1 (cycle 34 for CELLS=11).
- Each cycle of cell_ready=0 in OUT adds exactly one cycle.
- addr_b changes only on the transitions IDLE→ADDR and OUT→ADDR. It is stable through ADDR, WAIT and OUT.
- Port-B reads must not conflict with port-A writes to the same cell. Write-first or read-first behaviour is set by the RAM and is not specified here.

## Configuration
- BOARD_SCAN_CHECKSUM_EN defined:
  - checksum clears to 0 on accepted start;
  - on each accepted word, checksum←(checksum+cell_data) mod 2^DATA_W;
  - the final value is valid in the DONE cycle and holds until the next accepted start or reset.
- Not defined: checksum is driven constant 0 and the accumulator is not built. All other behaviour is identical.

## Test plan
- Reset, then load RAM[0..10]=0x0100..0x010A and pulse start with base=0, cell_ready=1. Required:
  - cell_valid first high 3 cycles after start;
  - words 0x0100..0x010A with indices 0..10 at 3-cycle spacing;
  - done one-cycle pulse at cycle 34;
  - busy low afterward.
- Backpressure: hold cell_ready=0 for 5 cycles on index 3. Required: cell_data=0x0103 and index 3 stay stable, addr_b does not change, and done shifts by exactly 5 cycles.
- Wrap: CELLS=4, base=1022, RAM[1022]=0xAAAA, RAM[1023]=0xBBBB, RAM[0]=0xCCCC, RAM[1]=0xDDDD. Required: addr_b sequence is 1022, 1023, 0, 1 and the data stream is AAAA, BBBB, CCCC, DDDD.
- Start pulses while busy (at cycles 5 and 20) and in the DONE cycle. Required: ignored, single scan, single done pulse.
- Reset asserted during WAIT of index 6. Required: all outputs return to reset values the next cycle, no done pulse, and a fresh start then runs a full scan from index 0.
- With BOARD_SCAN_CHECKSUM_EN and the first scenario's data: checksum=0x0B37 in the DONE cycle (sum of 0x0100..0x010A), held until the next start. Without the macro, checksum stays 0.
